// File: rtl/x_spisram.sv
// Crossbar-port responder that turns each accepted request into one byte-mode
// SPI mode-0 transaction to a 23K640 SRAM; one transaction in flight at a time.
module x_spisram #(
    parameter int CLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_accept,
    input  logic        i_rd_n_wr,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    output logic        o_ready,
    output logic [7:0]  o_rdata,
    output logic        o_sck,
    output logic        o_cs_n,
    output logic        o_mosi,
    input  logic        i_miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = (CLK_DIV > 1) ? 8'd1 : 8'd0;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    state_t      state;
    state_t      state_nx;
    req_t        req;
    logic [31:0] frame;
    logic [31:0] shreg;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic        tick;
    logic        sck;
    logic        mosi;
    logic        cs_n;
    logic        is_rd;
    logic [7:0]  rx_byte;
    logic [7:0]  rdata;

    assign req   = '{rd: i_rd_n_wr, addr: i_addr, wdata: i_wdata};
    assign frame = {req.rd ? 8'h03 : 8'h02, req.addr, req.rd ? 8'h00 : req.wdata};
    assign tick  = (div_cnt == DIV_LAST);

    assign o_sck   = sck;
    assign o_mosi  = mosi;
    assign o_cs_n  = cs_n;
    assign o_rdata = rdata;

    // A dedicated reset state keeps o_accept low while i_rst is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_RST;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RST:   state_nx = ST_IDLE;
            ST_IDLE:  if (i_valid) state_nx = ST_SHIFT;
            ST_SHIFT: if (tick && sck && bit_cnt == 5'd31) state_nx = ST_HOLD;
            ST_HOLD:  if (tick) state_nx = ST_DONE;
            ST_DONE:  state_nx = (CLK_DIV == 1) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (tick) state_nx = ST_IDLE;
            default:  state_nx = ST_RST;
        endcase
    end

    always_comb begin
        o_accept = 1'b0;
        o_ready  = 1'b0;
        case (state)
            ST_IDLE: o_accept = 1'b1;
            ST_DONE: o_ready  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            is_rd   <= 1'b0;
            rx_byte <= '0;
            rdata   <= '0;
        end else begin
            cs_n <= !(state_nx == ST_SHIFT || state_nx == ST_HOLD);
            case (state)
                ST_IDLE: begin
                    div_cnt <= '0;
                    if (i_valid) begin
                        shreg <= frame;
                        mosi  <= frame[31];
                        is_rd <= req.rd;
                    end
                end
                ST_SHIFT: begin
                    div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                    if (tick) begin
                        sck <= ~sck;
                        if (!sck) begin
                            // Rising edge: last eight periods carry the read byte.
                            if (is_rd && bit_cnt[4:3] == 2'b11)
                                rx_byte <= {rx_byte[6:0], i_miso};
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            shreg   <= {shreg[30:0], 1'b0};
                            mosi    <= (bit_cnt == 5'd31) ? 1'b0 : shreg[30];
                        end
                    end
                end
                ST_HOLD: begin
                    div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                    if (tick && is_rd)
                        rdata <= rx_byte;
                end
                // DONE already counts as the first CS-high cycle of the gap.
                ST_DONE: div_cnt <= GAP_LOAD;
                ST_GAP:  div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                default: div_cnt <= '0;
            endcase
        end
    end

endmodule
